multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style FSM that sequences a multicycle MIPS datapath (shared ALU, single unified memory, IR/MDR/A/B/ALUOut registers). It decodes the 6-bit opcode latched in IR and walks fetch/decode/execute/memory/writeback states. It supports R-type, lw (100011), sw (101011), beq (000100) and the data-init load-immediate (100000). Memory stalls are handled through a ready handshake.

Parameters:
HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
Op  in  6  opcode from IR[31:26]
Zero  in  1  ALU zero flag (datapath gates PC with PCWriteCond & Zero)
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  branch-conditional PC load
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR
MemtoReg  out  1  1 = MDR to register file, 0 = ALUOut
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ=8, IMM_EX=9, IMM_WB=10, JUMP=11 (JUMP only with the optional feature).
- Outputs are decoded purely from state, except the mem_ready qualification noted below. Any output not listed for a state is 0.
- Reset: on an edge with reset=1, state<=FETCH. While reset=1, all outputs are forced to 0 regardless of state, and illegal_op=0.
- Reset mid-operation (e.g. in MEMWR) drops MemWrite at once (combinational force). The FSM restarts at FETCH; no partial writeback.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. If mem_ready, go to DECODE; otherwise stay, with no PC/IR update (PC advances exactly once per instruction).
- DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 000000 -> RTYPE_EX
  - 100011, 101011 -> MEMADR
  - 000100 -> BEQ
  - 100000 -> IMM_EX
  - otherwise -> FETCH, with illegal_op=1 for this DECODE cycle only
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if Op=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH. MemWrite stays high for every stall cycle.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH. Taken/not-taken is resolved in the datapath via Zero; the FSM path is identical either way.
- IMM_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- Cycle counts with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, 100000 4. Each stall cycle adds 1.
- Op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Unreachable state codes (12-15) go to FETCH on the next edge, with all outputs 0.
- HANDSHAKE=0: FETCH/MEMRD/MEMWR always leave after 1 cycle.

Optional Feature:
MULTICYCLE_JUMP_EN.
- Defined: Op=000010 in DECODE -> JUMP. JUMP drives PCWrite=1, PCSource=10 for 1 cycle, then FETCH (3 cycles total).
- Undefined: 000010 is illegal (illegal_op pulse, return to FETCH), PCSource never equals 10, and state 11 is unreachable (treated as 12-15).

Test Plan:
- Reset held 2 cycles in any state -> all outputs 0, state=0. First cycle after release: MemRead=1, ALUSrcB=01.
- Op=000000, mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 only in state 7, with RegDst=1. PCWrite high exactly 1 cycle.
- Op=100011, mem_ready low for 3 cycles in MEMRD -> state sequence 0,1,2,3,3,3,3,4,0. MemRead and IorD=1 for all 4 MEMRD cycles. RegWrite with MemtoReg=1 in state 4.
- Op=101011, mem_ready=0 for 2 cycles in FETCH -> FETCH 3 cycles, with IRWrite/PCWrite only on the third. MEMWR asserts MemWrite=1 with IorD=1. Reset asserted in MEMWR -> MemWrite=0 the same cycle, state=0 next.
- Op=000100 -> 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01 in state 8. Op=111111 -> 0,1,0 with illegal_op pulsed exactly 1 cycle.
- Op=000010 with MULTICYCLE_JUMP_EN -> 0,1,11,0 with PCWrite=1, PCSource=10. Without the macro -> illegal_op=1, back to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Purpose : Moore control FSM sequencing a multicycle MIPS datapath (R-type, lw, sw, beq, load-imm).
// Latency : outputs decode from the registered state; R-type 4, lw 5, sw 4, beq 3, load-imm 4 cycles.
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready=0 (HANDSHAKE=1); HANDSHAKE=0 never stalls.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (forces all outputs to 0)
//   Op              opcode from IR[31:26], used only in DECODE and MEMADR
//   Zero            ALU zero flag; branch resolution happens in the datapath, so unused here
//   mem_ready       memory access completes this cycle
//   PCWrite .. PCSource   datapath control strobes and mux selects
//   illegal_op      one-cycle pulse in DECODE for an unsupported opcode
//   state           current state code (debug)
//
// Optional feature macro: MULTICYCLE_JUMP_EN adds the jump instruction (Op=000010, state JUMP=11).
module multicycle_control #(
    parameter int unsigned HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        IMM_EX   = 4'd9,
        IMM_WB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LI    = 6'b100000;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t cur, nxt, dec;
    logic   rdy;
    logic   unused_zero;

    assign unused_zero = Zero;
    assign rdy         = (HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state       = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // While reset is high, decode an unused code so every output falls to 0
    // in the same cycle (e.g. MemWrite drops immediately mid-store).
    assign dec = reset ? state_t'(4'd15) : cur;

    always_comb begin
        nxt         = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;

        case (dec)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // PC and IR load only on the completing cycle so the PC
                // advances exactly once per instruction.
                IRWrite = rdy;
                PCWrite = rdy;
                nxt     = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_RTYPE:     nxt = RTYPE_EX;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BEQ;
                    OP_LI:        nxt = IMM_EX;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         nxt = JUMP;
`endif
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = rdy ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = RTYPE_WB;
            end
            RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nxt         = FETCH;
            end
            IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = IMM_WB;
            end
            IMM_WB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = FETCH;
            end
`endif
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : randomized scoreboard bench for multicycle_control against an instruction-level model.
// Latency : one expected control word per clock, compared on the falling edge.
// Backpressure: memory stalls injected in FETCH/MEMRD/MEMWR through mem_ready.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    multicycle_control #(.HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegal_op}
    typedef struct packed {
        logic        chk_state;
        logic [3:0]  st;
        logic [16:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_RX = 6, S_RWB = 7, S_BEQ = 8, S_IX = 9, S_IWB = 10,
                   S_JUMP = 11;

    // Reference control table written straight from the state descriptions.
    function automatic logic [16:0] exp_word(input int st, input bit rdy, input bit ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: srcb = 2'b11;
            S_MEMADR: begin srca = 1; srcb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iord = 1; end
            S_RX:     begin srca = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rdst = 1; end
            S_BEQ:    begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            S_IX:     begin srca = 1; srcb = 2'b10; end
            S_IWB:    rw = 1;
            S_JUMP:   begin pcw = 1; pcs = 2'b10; end
            default:  ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        bit j = 1'b0;
`ifdef MULTICYCLE_JUMP_EN
        j = (o == 6'b000010);
`endif
        return j || o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b100000;
    endfunction

    // One clock of stimulus plus its expected response.
    task automatic issue(input int st, input bit rdy, input logic [5:0] opv, input bit ill);
        @(posedge clk); #1;
        reset     = 1'b0;
        Op        = opv;
        mem_ready = rdy;
        Zero      = 1'($urandom_range(0, 1));
        exp_q.push_back('{1'b1, 4'(st), exp_word(st, rdy, ill)});
    endtask

    task automatic hold_reset(input int ncyc, input bit first_known);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            reset     = 1'b1;
            Op        = 6'($urandom);
            mem_ready = 1'($urandom_range(0, 1));
            exp_q.push_back('{(i > 0) || first_known, 4'd0, 17'd0});
        end
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Whole instruction: fetch stalls, decode, then the opcode's path.
    // abort=1 raises reset in the first memory-access cycle.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input bit abort);
        int mst;
        for (int i = 0; i < fstall; i++) issue(S_FETCH, 1'b0, rop(), 1'b0);
        issue(S_FETCH, 1'b1, rop(), 1'b0);
        issue(S_DECODE, 1'($urandom_range(0, 1)), op, !is_legal(op));
        if (!is_legal(op)) return;
        case (op)
            6'b000000: begin
                issue(S_RX, 1'($urandom_range(0, 1)), rop(), 1'b0);
                issue(S_RWB, 1'($urandom_range(0, 1)), rop(), 1'b0);
            end
            6'b000100: issue(S_BEQ, 1'($urandom_range(0, 1)), rop(), 1'b0);
            6'b100000: begin
                issue(S_IX, 1'($urandom_range(0, 1)), rop(), 1'b0);
                issue(S_IWB, 1'($urandom_range(0, 1)), rop(), 1'b0);
            end
            6'b000010: issue(S_JUMP, 1'($urandom_range(0, 1)), rop(), 1'b0);
            default: begin
                issue(S_MEMADR, 1'($urandom_range(0, 1)), op, 1'b0);
                mst = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
                if (abort) begin
                    // Outputs must all be 0 in this cycle even though the
                    // registered state is still the memory state.
                    @(posedge clk); #1;
                    reset     = 1'b1;
                    mem_ready = 1'b0;
                    exp_q.push_back('{1'b1, 4'(mst), 17'd0});
                    return;
                end
                for (int i = 0; i < mstall; i++) issue(mst, 1'b0, rop(), 1'b0);
                issue(mst, 1'b1, rop(), 1'b0);
                if (op == 6'b100011) issue(S_MEMWB, 1'($urandom_range(0, 1)), rop(), 1'b0);
            end
        endcase
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] got;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
            n_checks++;
            if (got !== e.w) begin
                n_fail++;
                $display("FAIL ctrl cyc%0d state=%0d: got %05h required %05h", cyc, state, got, e.w);
            end
            if (e.chk_state) begin
                n_checks++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state cyc%0d: got %0d required %0d", cyc, state, e.st);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b100000; ops[5] = 6'b000010; ops[6] = 6'b111111;
        reset = 1'b1; Op = 6'd0; mem_ready = 1'b0; Zero = 1'b0;

        hold_reset(2, 1'b1);
        run_instr(6'b000000, 0, 0, 1'b0);          // R-type
        run_instr(6'b100011, 0, 3, 1'b0);          // lw with 3 MEMRD stalls
        run_instr(6'b101011, 2, 2, 1'b0);          // sw with fetch and store stalls
        run_instr(6'b101011, 0, 0, 1'b1);          // reset during MEMWR
        run_instr(6'b000100, 0, 0, 1'b0);          // beq
        run_instr(6'b111111, 0, 0, 1'b0);          // illegal
        run_instr(6'b000010, 1, 0, 1'b0);          // jump (or illegal without the feature)
        run_instr(6'b100000, 0, 0, 1'b0);          // load-immediate
        run_instr(6'b000000, 0, 0, 1'b0);
        hold_reset(2, 1'b0);                       // reset from mid-flow position
        run_instr(6'b100011, 0, 0, 1'b1);          // reset during MEMRD

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 40) == 0) hold_reset(2, 1'b0);
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
